mips_program_loader: RTL and testbench
======================================

Name: mips_program_loader

Overview:
Host-side loader and run controller for the MIPS pipeline. It takes a byte stream from a UART receiver, assembles 32-bit instruction words and writes them into the fetch-stage instruction memory. It holds the CPU in reset while loading, then releases it for free-run, halt or single-step. It acknowledges each command through a UART transmitter byte interface.

Parameters:
NB_BITS, 32, instruction word width (fixed at 4 bytes, MSB first)
NB_ADDR, 10, instruction memory word-address width (depth 2^NB_ADDR)
NB_BYTE, 8, UART byte width

Ports:
i_clk  in  1  system clock, shared with MIPS
i_rst  in  1  asynchronous, active-low reset
i_rx_data  in  NB_BYTE  received byte
i_rx_valid  in  1  one-cycle strobe, i_rx_data valid
i_tx_busy  in  1  transmitter busy; o_tx_start ignored while high
o_tx_data  out  NB_BYTE  byte to send
o_tx_start  out  1  one-cycle strobe, send o_tx_data
o_imem_addr  out  NB_ADDR  instruction memory word address
o_imem_data  out  NB_BITS  instruction word
o_imem_we  out  1  instruction memory write enable
o_cpu_rst_n  out  1  MIPS reset, active low (0 = held in reset)
o_cpu_clk_en  out  1  MIPS pipeline advance enable

Behaviour:
- Reset (async, i_rst=0): state IDLE. o_imem_we=0, o_imem_addr=0, o_imem_data=0, o_tx_start=0, o_tx_data=0, o_cpu_rst_n=0, o_cpu_clk_en=0. Internal counters cleared.
- Commands are accepted only in IDLE, on i_rx_valid:
  - 'L' 0x4C: drive o_cpu_rst_n=0 and o_cpu_clk_en=0, then go to CNT_HI.
  - 'R' 0x52: o_cpu_rst_n=1, o_cpu_clk_en=1 (free run), then ACK.
  - 'H' 0x48: o_cpu_clk_en=0, o_cpu_rst_n unchanged, then ACK.
  - 'S' 0x53: o_cpu_rst_n=1, o_cpu_clk_en=1 for exactly one cycle, then ACK. If the CPU is free-running, it halts after that cycle.
  - Any other byte: queue NAK 0x15, go to ACK.
- CNT_HI / CNT_LO: take the 16-bit word count N, big-endian.
  - N=0: queue ACK 0x06 without writing.
  - N>2^NB_ADDR: queue NAK. Later bytes are parsed as commands.
  - Otherwise: o_imem_addr=0, byte counter=0, go to DATA.
- DATA: shift bytes MSB first into an NB_BITS assembly register.
  - On the 4th byte, go to WRITE the next cycle.
  - Bytes arriving while in WRITE are not possible at UART rates; none are required to be captured.
- WRITE: o_imem_we=1 for exactly one cycle, carrying the current o_imem_addr and o_imem_data.
  - Next cycle: o_imem_addr increments and the word counter increments.
  - If the word count reaches N: queue ACK 0x06, go to ACK. Otherwise return to DATA.
  - o_imem_addr wraps to 0 only when N=2^NB_ADDR.
- ACK: wait until i_tx_busy=0, then o_tx_start=1 for one cycle with o_tx_data = the queued byte, then go to IDLE.
  - i_rx_valid received while in ACK is dropped.
- Latency:
  - Last data byte strobe to o_imem_we: 1 cycle.
  - Final o_imem_we to o_tx_start: 2 cycles when the TX is idle.
  - Command byte to o_cpu_clk_en change: 1 cycle.
- o_cpu_rst_n and o_cpu_clk_en are registered outputs and never glitch.
- Reset asserted mid-load: everything returns to reset values. Memory contents already written are left as they are.

Decomposition:
- Shared include (alongside `NB_BITS`): command codes `CMD_LOAD`, `CMD_RUN`, `CMD_HALT`, `CMD_STEP`; reply codes `RSP_ACK`, `RSP_NAK`; state encoding localparams.
- One natural sub-module: loader_word_assembler. It holds the byte shifter and the 2-bit byte counter, and produces a word-valid strobe. The FSM stays in the top module.

Test Plan:
- Reset release: all outputs at reset values. Send 'R' -> o_cpu_rst_n=1, o_cpu_clk_en=1, one o_tx_start with 0x06.
- Load: 'L', 0x00, 0x02, then 20 08 00 05 24 09 00 03 -> writes addr0=0x20080005 and addr1=0x24090003, one cycle each. o_cpu_rst_n=0 during the load. ACK follows 2 cycles after the last write.
- Count 0 and oversize count: 'L',00,00 -> ACK, no writes. 'L', count 2^NB_ADDR+1 -> NAK 0x15, no writes.
- Step: after load, 'S' three times -> o_cpu_clk_en high for exactly 1 cycle each, 3 ACKs. 'H' during 'R' -> clk_en drops the cycle after the strobe.
- TX backpressure: hold i_tx_busy=1 for 50 cycles after a command -> o_tx_start asserts exactly once, on the first cycle busy=0. Bytes received meanwhile are ignored.
- Async reset after 2 of 4 data bytes -> immediate reset values. A fresh full load then writes from addr 0 with a correct word.

Source files
------------

// File: rtl/mips_program_loader_pkg.sv
// -----------------------------------------------------------------------------
// mips_program_loader_pkg
//   Shared constants for the MIPS program loader: data widths, host command
//   and reply byte codes, and the loader FSM state encoding.
//   No ports (package).
// -----------------------------------------------------------------------------
package mips_program_loader_pkg;

  // Instruction word width (always 4 bytes, sent MSB first).
  localparam int NB_BITS  = 32;
  // Instruction memory word-address width; memory depth is 2**NB_ADDR words.
  localparam int NB_ADDR  = 10;
  // UART byte width.
  localparam int NB_BYTE  = 8;
  // Word-count field is two UART bytes, big-endian.
  localparam int NB_COUNT = 2 * NB_BYTE;
  // Largest legal word count (a full memory image).
  localparam int MEM_DEPTH = 1 << NB_ADDR;

  // Host command codes (ASCII).
  localparam logic [NB_BYTE-1:0] CMD_LOAD = 8'h4C;  // 'L'
  localparam logic [NB_BYTE-1:0] CMD_RUN  = 8'h52;  // 'R'
  localparam logic [NB_BYTE-1:0] CMD_HALT = 8'h48;  // 'H'
  localparam logic [NB_BYTE-1:0] CMD_STEP = 8'h53;  // 'S'

  // Reply codes (ASCII control characters).
  localparam logic [NB_BYTE-1:0] RSP_ACK  = 8'h06;
  localparam logic [NB_BYTE-1:0] RSP_NAK  = 8'h15;

  // Loader FSM state encoding.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CNT_HI = 3'd1,
    ST_CNT_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_ACK    = 3'd5
  } loader_state_t;

  // True when a requested word count cannot fit in instruction memory.
  function automatic logic count_exceeds_depth(input logic [NB_COUNT-1:0] n);
    return int'(n) > MEM_DEPTH;
  endfunction

endpackage

// File: rtl/mips_program_loader_word_assembler.sv
// -----------------------------------------------------------------------------
// loader_word_assembler
//   Collects UART bytes MSB first into an instruction word. A 2-bit byte
//   counter tracks the position inside the word; o_word_valid is raised in
//   the same cycle as the byte that completes a word, together with the
//   completed word on o_word_next, so the caller can latch it without an
//   extra cycle of latency.
//
// Ports:
//   i_clk         system clock
//   i_rst         asynchronous active-low reset
//   i_clear       synchronous clear of shifter and byte counter (new load)
//   i_byte_valid  i_byte carries a payload byte this cycle
//   i_byte        payload byte
//   o_word_next   shifter contents including the current byte
//   o_word_valid  current byte is the last byte of a word
// -----------------------------------------------------------------------------
module loader_word_assembler
  import mips_program_loader_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clear,
  input  logic               i_byte_valid,
  input  logic [NB_BYTE-1:0] i_byte,
  output logic [NB_BITS-1:0] o_word_next,
  output logic               o_word_valid
);

  localparam int          NB_LANES  = NB_BITS / NB_BYTE;
  localparam logic [1:0]  LAST_LANE = 2'(NB_LANES - 1);

  logic [NB_BITS-1:0] shift_reg;
  logic [NB_BITS-1:0] shift_next;
  logic [1:0]         byte_cnt_reg;

  // Byte-lane shift: the new byte enters lane 0, every lane moves up by one,
  // so after four bytes the first byte received sits in the top lane.
  generate
    for (genvar gi = 0; gi < NB_LANES; gi++) begin : g_lane
      if (gi == 0) begin : g_lsb
        assign shift_next[NB_BYTE-1:0] = i_byte;
      end else begin : g_upper
        assign shift_next[gi*NB_BYTE +: NB_BYTE] = shift_reg[(gi-1)*NB_BYTE +: NB_BYTE];
      end
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      shift_reg    <= '0;
      byte_cnt_reg <= 2'd0;
    end else if (i_clear) begin
      shift_reg    <= '0;
      byte_cnt_reg <= 2'd0;
    end else if (i_byte_valid) begin
      shift_reg    <= shift_next;
      // Counter wraps naturally after the fourth byte.
      byte_cnt_reg <= byte_cnt_reg + 2'd1;
    end
  end

  assign o_word_next  = shift_next;
  assign o_word_valid = i_byte_valid && (byte_cnt_reg == LAST_LANE);

endmodule

// File: rtl/mips_program_loader.sv
// -----------------------------------------------------------------------------
// mips_program_loader
//   Host-side loader and run controller for the MIPS pipeline. Parses command
//   bytes from a UART receiver, loads instruction words into the fetch-stage
//   instruction memory while holding the CPU in reset, controls free-run /
//   halt / single-step of the CPU, and replies ACK/NAK through a UART
//   transmitter byte interface.
//
// Ports:
//   i_clk         system clock, shared with the MIPS core
//   i_rst         asynchronous active-low reset
//   i_rx_data     received byte
//   i_rx_valid    one-cycle strobe, i_rx_data valid
//   i_tx_busy     transmitter busy
//   o_tx_data     byte to transmit
//   o_tx_start    one-cycle strobe, transmit o_tx_data
//   o_imem_addr   instruction memory word address
//   o_imem_data   instruction word to write
//   o_imem_we     instruction memory write enable (one cycle per word)
//   o_cpu_rst_n   CPU reset, active low
//   o_cpu_clk_en  CPU pipeline advance enable
// -----------------------------------------------------------------------------
module mips_program_loader
  import mips_program_loader_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_valid,
  input  logic               i_tx_busy,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic [NB_ADDR-1:0] o_imem_addr,
  output logic [NB_BITS-1:0] o_imem_data,
  output logic               o_imem_we,
  output logic               o_cpu_rst_n,
  output logic               o_cpu_clk_en
);

  localparam logic [NB_COUNT-1:0] COUNT_ONE = NB_COUNT'(1);
  localparam logic [NB_ADDR-1:0]  ADDR_ONE  = NB_ADDR'(1);

  loader_state_t       state_reg, state_next;
  logic [NB_BYTE-1:0]  count_hi_reg, count_hi_next;
  logic [NB_COUNT-1:0] count_reg, count_next;
  logic [NB_COUNT-1:0] word_cnt_reg, word_cnt_next;
  logic [NB_ADDR-1:0]  addr_reg, addr_next;
  logic [NB_BITS-1:0]  data_reg, data_next;
  logic                we_reg, we_next;
  logic                tx_start_reg, tx_start_next;
  logic [NB_BYTE-1:0]  tx_data_reg, tx_data_next;
  logic [NB_BYTE-1:0]  rsp_reg, rsp_next;
  logic                cpu_rst_n_reg, cpu_rst_n_next;
  logic                cpu_clk_en_reg, cpu_clk_en_next;
  logic                step_reg, step_next;

  logic [NB_COUNT-1:0] rx_count;
  logic [NB_COUNT-1:0] word_cnt_inc;
  logic                asm_clear;
  logic                asm_byte_valid;
  logic [NB_BITS-1:0]  asm_word;
  logic                asm_word_valid;

  // Second count byte completes the big-endian word count.
  assign rx_count     = {count_hi_reg, i_rx_data};
  assign word_cnt_inc = word_cnt_reg + COUNT_ONE;

  loader_word_assembler u_word_assembler (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clear      (asm_clear),
    .i_byte_valid (asm_byte_valid),
    .i_byte       (i_rx_data),
    .o_word_next  (asm_word),
    .o_word_valid (asm_word_valid)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_reg      <= ST_IDLE;
      count_hi_reg   <= '0;
      count_reg      <= '0;
      word_cnt_reg   <= '0;
      addr_reg       <= '0;
      data_reg       <= '0;
      we_reg         <= 1'b0;
      tx_start_reg   <= 1'b0;
      tx_data_reg    <= '0;
      rsp_reg        <= '0;
      cpu_rst_n_reg  <= 1'b0;
      cpu_clk_en_reg <= 1'b0;
      step_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      count_hi_reg   <= count_hi_next;
      count_reg      <= count_next;
      word_cnt_reg   <= word_cnt_next;
      addr_reg       <= addr_next;
      data_reg       <= data_next;
      we_reg         <= we_next;
      tx_start_reg   <= tx_start_next;
      tx_data_reg    <= tx_data_next;
      rsp_reg        <= rsp_next;
      cpu_rst_n_reg  <= cpu_rst_n_next;
      cpu_clk_en_reg <= cpu_clk_en_next;
      step_reg       <= step_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    count_hi_next   = count_hi_reg;
    count_next      = count_reg;
    word_cnt_next   = word_cnt_reg;
    addr_next       = addr_reg;
    data_next       = data_reg;
    we_next         = 1'b0;
    tx_start_next   = 1'b0;
    tx_data_next    = tx_data_reg;
    rsp_next        = rsp_reg;
    cpu_rst_n_next  = cpu_rst_n_reg;
    cpu_clk_en_next = cpu_clk_en_reg;
    step_next       = step_reg;
    asm_clear       = 1'b0;
    asm_byte_valid  = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (i_rx_valid) begin
          state_next = ST_ACK;
          rsp_next   = RSP_ACK;
          case (i_rx_data)
            CMD_LOAD: begin
              cpu_rst_n_next  = 1'b0;
              cpu_clk_en_next = 1'b0;
              state_next      = ST_CNT_HI;
            end
            CMD_RUN: begin
              cpu_rst_n_next  = 1'b1;
              cpu_clk_en_next = 1'b1;
            end
            CMD_HALT: begin
              cpu_clk_en_next = 1'b0;
            end
            CMD_STEP: begin
              // Enable rises now; the ACK state drops it again after exactly
              // one cycle (ACK always lasts at least one cycle).
              cpu_rst_n_next  = 1'b1;
              cpu_clk_en_next = 1'b1;
              step_next       = 1'b1;
            end
            default: begin
              rsp_next = RSP_NAK;
            end
          endcase
        end
      end

      ST_CNT_HI: begin
        if (i_rx_valid) begin
          count_hi_next = i_rx_data;
          state_next    = ST_CNT_LO;
        end
      end

      ST_CNT_LO: begin
        if (i_rx_valid) begin
          count_next = rx_count;
          if (rx_count == '0) begin
            rsp_next   = RSP_ACK;
            state_next = ST_ACK;
          end else if (count_exceeds_depth(rx_count)) begin
            rsp_next   = RSP_NAK;
            state_next = ST_ACK;
          end else begin
            addr_next     = '0;
            word_cnt_next = '0;
            asm_clear     = 1'b1;
            state_next    = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        asm_byte_valid = i_rx_valid;
        if (asm_word_valid) begin
          data_next  = asm_word;
          we_next    = 1'b1;
          state_next = ST_WRITE;
        end
      end

      ST_WRITE: begin
        // Address is NB_ADDR wide, so it wraps to 0 only after a full image.
        addr_next     = addr_reg + ADDR_ONE;
        word_cnt_next = word_cnt_inc;
        if (word_cnt_inc == count_reg) begin
          rsp_next   = RSP_ACK;
          state_next = ST_ACK;
        end else begin
          state_next = ST_DATA;
        end
      end

      ST_ACK: begin
        if (step_reg) begin
          cpu_clk_en_next = 1'b0;
          step_next       = 1'b0;
        end
        if (!i_tx_busy) begin
          tx_start_next = 1'b1;
          tx_data_next  = rsp_reg;
          state_next    = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign o_tx_data    = tx_data_reg;
  assign o_tx_start   = tx_start_reg;
  assign o_imem_addr  = addr_reg;
  assign o_imem_data  = data_reg;
  assign o_imem_we    = we_reg;
  assign o_cpu_rst_n  = cpu_rst_n_reg;
  assign o_cpu_clk_en = cpu_clk_en_reg;

endmodule

// File: tb/tb_mips_program_loader.sv
module tb_mips_program_loader;
  import mips_program_loader_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NB_BYTE-1:0] rx_data = '0;
  logic               rx_valid = 1'b0;
  logic               tx_busy = 1'b0;
  logic [NB_BYTE-1:0] tx_data;
  logic               tx_start;
  logic [NB_ADDR-1:0] imem_addr;
  logic [NB_BITS-1:0] imem_data;
  logic               imem_we;
  logic               cpu_rst_n;
  logic               cpu_clk_en;

  mips_program_loader dut (
    .i_clk        (clk),
    .i_rst        (rst_n),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .i_tx_busy    (tx_busy),
    .o_tx_data    (tx_data),
    .o_tx_start   (tx_start),
    .o_imem_addr  (imem_addr),
    .o_imem_data  (imem_data),
    .o_imem_we    (imem_we),
    .o_cpu_rst_n  (cpu_rst_n),
    .o_cpu_clk_en (cpu_clk_en)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vec_cnt = 0;
  int err_cnt = 0;
  int last_strobe_cyc = 0;

  logic [NB_ADDR-1:0] we_addr_q[$];
  logic [NB_BITS-1:0] we_data_q[$];
  int                 we_cyc_q[$];
  logic [NB_BYTE-1:0] tx_q[$];
  int                 tx_cyc_q[$];

  // Log every write and every transmit strobe, one per cycle high.
  always @(negedge clk) begin
    if (imem_we) begin
      we_addr_q.push_back(imem_addr);
      we_data_q.push_back(imem_data);
      we_cyc_q.push_back(cyc);
    end
    if (tx_start) begin
      tx_q.push_back(tx_data);
      tx_cyc_q.push_back(cyc);
    end
  end

  task automatic clear_log();
    we_addr_q.delete(); we_data_q.delete(); we_cyc_q.delete();
    tx_q.delete(); tx_cyc_q.delete();
  endtask

  task automatic send_byte(input logic [NB_BYTE-1:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    last_strobe_cyc = cyc;
    $display("rx byte 0x%02h  cyc=%0d cpu_rst_n=%0b clk_en=%0b", b, cyc, cpu_rst_n, cpu_clk_en);
  endtask

  task automatic send_load_hdr(input logic [15:0] n);
    send_byte(CMD_LOAD);
    send_byte(n[15:8]);
    send_byte(n[7:0]);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic wait_tx(input int n, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk); #1;
      if (tx_q.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  function automatic logic [NB_BYTE-1:0] tx_at(input int i);
    return (tx_q.size() > i) ? tx_q[i] : 8'hxx;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vec_cnt++; if (imem_we !== 1'b0) begin err_cnt++; $display("FAIL reset_we got=%b exp=0", imem_we); end
    vec_cnt++; if (imem_addr !== '0) begin err_cnt++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
    vec_cnt++; if (imem_data !== '0) begin err_cnt++; $display("FAIL reset_data got=%h exp=0", imem_data); end
    vec_cnt++; if (tx_start !== 1'b0) begin err_cnt++; $display("FAIL reset_tx_start got=%b exp=0", tx_start); end
    vec_cnt++; if (tx_data !== '0) begin err_cnt++; $display("FAIL reset_tx_data got=%h exp=0", tx_data); end
    vec_cnt++; if (cpu_rst_n !== 1'b0) begin err_cnt++; $display("FAIL reset_cpu_rst_n got=%b exp=0", cpu_rst_n); end
    vec_cnt++; if (cpu_clk_en !== 1'b0) begin err_cnt++; $display("FAIL reset_clk_en got=%b exp=0", cpu_clk_en); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    vec_cnt++; if (cpu_rst_n !== 1'b0 || cpu_clk_en !== 1'b0 || tx_start !== 1'b0)
      begin err_cnt++; $display("FAIL post_reset_idle got=%b%b%b exp=000", cpu_rst_n, cpu_clk_en, tx_start); end
    $display("test_reset done");
  endtask

  task automatic test_run();
    bit ok;
    clear_log();
    send_byte(CMD_RUN);
    vec_cnt++; if (cpu_rst_n !== 1'b1) begin err_cnt++; $display("FAIL run_rst_n got=%b exp=1", cpu_rst_n); end
    vec_cnt++; if (cpu_clk_en !== 1'b1) begin err_cnt++; $display("FAIL run_clk_en got=%b exp=1", cpu_clk_en); end
    wait_tx(1, 10, ok);
    vec_cnt++; if (!ok) begin err_cnt++; $display("FAIL run_ack_timeout got=none exp=tx_start"); end
    repeat (5) @(negedge clk); #1;
    vec_cnt++; if (tx_q.size() != 1) begin err_cnt++; $display("FAIL run_ack_count got=%0d exp=1", tx_q.size()); end
    vec_cnt++; if (tx_at(0) !== RSP_ACK) begin err_cnt++; $display("FAIL run_ack_byte got=%h exp=%h", tx_at(0), RSP_ACK); end
    $display("test_run done");
  endtask

  task automatic test_load();
    bit ok;
    int strobe1;
    clear_log();
    send_byte(CMD_LOAD);
    vec_cnt++; if (cpu_rst_n !== 1'b0 || cpu_clk_en !== 1'b0)
      begin err_cnt++; $display("FAIL load_cpu_hold got=%b%b exp=00", cpu_rst_n, cpu_clk_en); end
    send_byte(8'h00);
    send_byte(8'h02);
    send_word(32'h20080005);
    strobe1 = last_strobe_cyc;
    vec_cnt++; if (cpu_rst_n !== 1'b0) begin err_cnt++; $display("FAIL load_mid_rst_n got=%b exp=0", cpu_rst_n); end
    send_word(32'h24090003);
    wait_tx(1, 10, ok);
    vec_cnt++; if (!ok) begin err_cnt++; $display("FAIL load_ack_timeout got=none exp=tx_start"); end
    vec_cnt++; if (we_addr_q.size() != 2) begin err_cnt++; $display("FAIL load_write_count got=%0d exp=2", we_addr_q.size()); end
    if (we_addr_q.size() == 2) begin
      vec_cnt++; if (we_addr_q[0] !== 10'd0 || we_data_q[0] !== 32'h20080005)
        begin err_cnt++; $display("FAIL load_word0 got=%h@%0d exp=20080005@0", we_data_q[0], we_addr_q[0]); end
      vec_cnt++; if (we_addr_q[1] !== 10'd1 || we_data_q[1] !== 32'h24090003)
        begin err_cnt++; $display("FAIL load_word1 got=%h@%0d exp=24090003@1", we_data_q[1], we_addr_q[1]); end
      vec_cnt++; if (we_cyc_q[0] != strobe1) begin err_cnt++; $display("FAIL load_we_latency0 got=%0d exp=%0d", we_cyc_q[0], strobe1); end
      vec_cnt++; if (we_cyc_q[1] != last_strobe_cyc) begin err_cnt++; $display("FAIL load_we_latency1 got=%0d exp=%0d", we_cyc_q[1], last_strobe_cyc); end
      if (tx_cyc_q.size() > 0) begin
        vec_cnt++; if (tx_cyc_q[0] != we_cyc_q[1] + 2)
          begin err_cnt++; $display("FAIL load_ack_latency got=%0d exp=%0d", tx_cyc_q[0], we_cyc_q[1] + 2); end
      end
    end
    vec_cnt++; if (tx_at(0) !== RSP_ACK) begin err_cnt++; $display("FAIL load_ack_byte got=%h exp=%h", tx_at(0), RSP_ACK); end
    vec_cnt++; if (imem_addr !== 10'd2) begin err_cnt++; $display("FAIL load_final_addr got=%0d exp=2", imem_addr); end
    vec_cnt++; if (cpu_rst_n !== 1'b0) begin err_cnt++; $display("FAIL load_end_rst_n got=%b exp=0", cpu_rst_n); end
    $display("test_load done");
  endtask

  task automatic test_count_edges();
    bit ok;
    clear_log();
    send_load_hdr(16'h0000);
    wait_tx(1, 10, ok);
    vec_cnt++; if (tx_at(0) !== RSP_ACK) begin err_cnt++; $display("FAIL count0_reply got=%h exp=%h", tx_at(0), RSP_ACK); end
    vec_cnt++; if (we_addr_q.size() != 0) begin err_cnt++; $display("FAIL count0_writes got=%0d exp=0", we_addr_q.size()); end
    clear_log();
    send_load_hdr(16'h0401);
    wait_tx(1, 10, ok);
    vec_cnt++; if (tx_at(0) !== RSP_NAK) begin err_cnt++; $display("FAIL oversize_reply got=%h exp=%h", tx_at(0), RSP_NAK); end
    vec_cnt++; if (we_addr_q.size() != 0) begin err_cnt++; $display("FAIL oversize_writes got=%0d exp=0", we_addr_q.size()); end
    clear_log();
    send_byte(CMD_HALT);
    wait_tx(1, 10, ok);
    vec_cnt++; if (tx_at(0) !== RSP_ACK) begin err_cnt++; $display("FAIL after_nak_cmd got=%h exp=%h", tx_at(0), RSP_ACK); end
    clear_log();
    send_byte(8'h58);
    wait_tx(1, 10, ok);
    vec_cnt++; if (tx_at(0) !== RSP_NAK) begin err_cnt++; $display("FAIL unknown_cmd got=%h exp=%h", tx_at(0), RSP_NAK); end
    $display("test_count_edges done");
  endtask

  task automatic test_step();
    bit ok;
    clear_log();
    for (int k = 0; k < 3; k++) begin
      send_byte(CMD_STEP);
      vec_cnt++; if (cpu_clk_en !== 1'b1 || cpu_rst_n !== 1'b1)
        begin err_cnt++; $display("FAIL step%0d_pulse got=%b%b exp=11", k, cpu_rst_n, cpu_clk_en); end
      @(negedge clk);
      vec_cnt++; if (cpu_clk_en !== 1'b0) begin err_cnt++; $display("FAIL step%0d_drop got=%b exp=0", k, cpu_clk_en); end
      wait_tx(k + 1, 10, ok);
    end
    vec_cnt++; if (tx_q.size() != 3) begin err_cnt++; $display("FAIL step_ack_count got=%0d exp=3", tx_q.size()); end
    vec_cnt++; if (tx_at(2) !== RSP_ACK) begin err_cnt++; $display("FAIL step_ack_byte got=%h exp=%h", tx_at(2), RSP_ACK); end
    // Step while free-running halts after the single cycle.
    send_byte(CMD_RUN);
    wait_tx(4, 10, ok);
    repeat (3) @(negedge clk);
    vec_cnt++; if (cpu_clk_en !== 1'b1) begin err_cnt++; $display("FAIL run_hold got=%b exp=1", cpu_clk_en); end
    send_byte(CMD_STEP);
    @(negedge clk);
    vec_cnt++; if (cpu_clk_en !== 1'b0) begin err_cnt++; $display("FAIL step_from_run got=%b exp=0", cpu_clk_en); end
    wait_tx(5, 10, ok);
    send_byte(CMD_RUN);
    wait_tx(6, 10, ok);
    send_byte(CMD_HALT);
    vec_cnt++; if (cpu_clk_en !== 1'b0 || cpu_rst_n !== 1'b1)
      begin err_cnt++; $display("FAIL halt got=%b%b exp=10", cpu_rst_n, cpu_clk_en); end
    wait_tx(7, 10, ok);
    vec_cnt++; if (!ok) begin err_cnt++; $display("FAIL halt_ack_timeout got=%0d exp=7", tx_q.size()); end
    $display("test_step done");
  endtask

  task automatic test_backpressure();
    bit ok;
    int drop_cyc;
    clear_log();
    tx_busy = 1'b1;
    send_byte(CMD_RUN);
    vec_cnt++; if (cpu_clk_en !== 1'b1) begin err_cnt++; $display("FAIL bp_run got=%b exp=1", cpu_clk_en); end
    repeat (20) @(negedge clk);
    send_byte(CMD_HALT);
    send_byte(CMD_STEP);
    repeat (26) @(negedge clk); #1;
    vec_cnt++; if (tx_q.size() != 0) begin err_cnt++; $display("FAIL bp_no_tx got=%0d exp=0", tx_q.size()); end
    vec_cnt++; if (cpu_clk_en !== 1'b1) begin err_cnt++; $display("FAIL bp_dropped_cmds got=%b exp=1", cpu_clk_en); end
    @(negedge clk);
    tx_busy  = 1'b0;
    drop_cyc = cyc;
    wait_tx(1, 10, ok);
    repeat (5) @(negedge clk); #1;
    vec_cnt++; if (tx_q.size() != 1) begin err_cnt++; $display("FAIL bp_tx_count got=%0d exp=1", tx_q.size()); end
    if (tx_cyc_q.size() > 0) begin
      vec_cnt++; if (tx_cyc_q[0] != drop_cyc + 1)
        begin err_cnt++; $display("FAIL bp_tx_cycle got=%0d exp=%0d", tx_cyc_q[0], drop_cyc + 1); end
    end
    vec_cnt++; if (tx_at(0) !== RSP_ACK) begin err_cnt++; $display("FAIL bp_tx_byte got=%h exp=%h", tx_at(0), RSP_ACK); end
    $display("test_backpressure done");
  endtask

  task automatic test_async_reset();
    bit ok;
    clear_log();
    send_load_hdr(16'h0001);
    send_byte(8'hDE);
    send_byte(8'hAD);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    vec_cnt++; if (tx_data !== '0) begin err_cnt++; $display("FAIL arst_tx_data got=%h exp=0", tx_data); end
    vec_cnt++; if (imem_data !== '0) begin err_cnt++; $display("FAIL arst_imem_data got=%h exp=0", imem_data); end
    vec_cnt++; if (imem_we !== 1'b0 || imem_addr !== '0 || tx_start !== 1'b0)
      begin err_cnt++; $display("FAIL arst_ctrl got=%b/%0d/%b exp=0/0/0", imem_we, imem_addr, tx_start); end
    vec_cnt++; if (cpu_rst_n !== 1'b0 || cpu_clk_en !== 1'b0)
      begin err_cnt++; $display("FAIL arst_cpu got=%b%b exp=00", cpu_rst_n, cpu_clk_en); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_log();
    send_load_hdr(16'h0001);
    send_word(32'h3C011234);
    wait_tx(1, 10, ok);
    vec_cnt++; if (we_addr_q.size() != 1) begin err_cnt++; $display("FAIL arst_reload_count got=%0d exp=1", we_addr_q.size()); end
    if (we_addr_q.size() > 0) begin
      vec_cnt++; if (we_addr_q[0] !== 10'd0 || we_data_q[0] !== 32'h3C011234)
        begin err_cnt++; $display("FAIL arst_reload_word got=%h@%0d exp=3c011234@0", we_data_q[0], we_addr_q[0]); end
    end
    vec_cnt++; if (tx_at(0) !== RSP_ACK) begin err_cnt++; $display("FAIL arst_reload_ack got=%h exp=%h", tx_at(0), RSP_ACK); end
    $display("test_async_reset done");
  endtask

  task automatic test_full_depth();
    bit ok;
    int bad;
    logic [31:0] w;
    clear_log();
    send_load_hdr(16'h0400);
    for (int i = 0; i < MEM_DEPTH; i++) begin
      w = {16'hA55A, 16'(i)};
      send_word(w);
    end
    wait_tx(1, 10, ok);
    vec_cnt++; if (we_addr_q.size() != MEM_DEPTH)
      begin err_cnt++; $display("FAIL full_write_count got=%0d exp=%0d", we_addr_q.size(), MEM_DEPTH); end
    bad = 0;
    for (int i = 0; i < we_addr_q.size(); i++) begin
      w = {16'hA55A, 16'(i)};
      if (we_addr_q[i] !== NB_ADDR'(i) || we_data_q[i] !== w) bad++;
    end
    vec_cnt++; if (bad != 0) begin err_cnt++; $display("FAIL full_contents got=%0d bad exp=0 bad", bad); end
    vec_cnt++; if (imem_addr !== '0) begin err_cnt++; $display("FAIL full_addr_wrap got=%0d exp=0", imem_addr); end
    vec_cnt++; if (tx_at(0) !== RSP_ACK) begin err_cnt++; $display("FAIL full_ack got=%h exp=%h", tx_at(0), RSP_ACK); end
    $display("test_full_depth done");
  endtask

  initial begin
    test_reset();
    test_run();
    test_load();
    test_count_edges();
    test_step();
    test_backpressure();
    test_async_reset();
    test_full_depth();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
